// File: rtl/mad_risc_processor_core.sv
// mad_risc_processor_core
//   16-bit single-cycle RISC core with eight GPRs (R0..R7), Z/N/C flags
//   and a unified MEM_DEPTH x 16 instruction/data memory. Every
//   instruction completes on one rising edge of Clk.
//
//   Memory reads are combinational and writes happen on the Clk edge.
//   Memory is never reset. It is preloaded from outside the core, either
//   by the memory-init flow of the target or by a simulation environment.
//   M[0] holds the reset vector and M[1] holds the interrupt vector.
//
// Ports
//   Clk  in   1   clock, all state updates on the rising edge
//   Rst  in   1   asynchronous active-low reset
//   In   in   16  input port, sampled by IN
//   Out  out  16  output port register, written by OUT
//   Int  in   1   interrupt request, rising edge latched
//
// Configuration
//   MAD_INTERRUPT_EN : when defined, adds interrupt support (edge latch,
//                      pending flag, EPC and saved flags, RTI). When it is
//                      undefined, Int is ignored and RTI acts as a NOP.
module mad_risc_processor_core #(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] In,
  output logic [15:0] Out,
  input  logic        Int
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR  = 4'h4, OP_NOT = 4'h5, OP_INC = 4'h6,
                         OP_MOV = 4'h7, OP_IN  = 4'h8, OP_OUT = 4'h9,
                         OP_LDI = 4'hA, OP_LDD = 4'hB, OP_STD = 4'hC,
                         OP_JZ  = 4'hD, OP_JMP = 4'hE, OP_SYS = 4'hF;

  logic [15:0]   mem [MEM_DEPTH];
  logic [15:0]   regs [8];
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic          z, n, c;
  logic          halted;

  logic [15:0]   instr;
  logic [3:0]    op;
  logic [2:0]    rd, rs;
  logic [8:0]    imm9;
  logic [15:0]   rd_val, rs_val, mem_rdata;
  logic [16:0]   sum17, diff17, inc17;

  logic          exec;       // the instruction at pc executes on this edge
  logic          take_irq;
  logic          mem_we;
  logic [7:0]    rf_we;
  logic [15:0]   rf_wdata;

`ifdef MAD_INTERRUPT_EN
  logic          int_q;
  logic          pending;
  logic          in_isr;
  logic [AW-1:0] epc;
  logic [2:0]    saved_flags;

  assign take_irq = pending && !in_isr;
`else
  logic          unused_int;

  assign unused_int = Int;
  assign take_irq   = 1'b0;
`endif

  // Decode and operand fetch (all combinational)
  assign instr     = mem[pc];
  assign op        = instr[15:12];
  assign rd        = instr[11:9];
  assign rs        = instr[8:6];
  assign imm9      = instr[8:0];
  assign rd_val    = regs[rd];
  assign rs_val    = regs[rs];
  assign mem_rdata = mem[rs_val[AW-1:0]];
  assign pc_inc    = pc + AW'(1);

  assign sum17  = {1'b0, rd_val} + {1'b0, rs_val};
  // Bit 16 of the 17-bit difference is the borrow, i.e. rd < rs unsigned.
  assign diff17 = {1'b0, rd_val} - {1'b0, rs_val};
  assign inc17  = {1'b0, rd_val} + 17'd1;

  assign exec   = !take_irq && !halted;
  // No memory write while reset is held.
  assign mem_we = Rst && exec && (op == OP_STD);

  // Register-file write port
  always_comb begin
    rf_wdata = '0;
    rf_we    = '0;
    if (exec) begin
      unique case (op)
        OP_ADD: rf_wdata = sum17[15:0];
        OP_SUB: rf_wdata = diff17[15:0];
        OP_AND: rf_wdata = rd_val & rs_val;
        OP_OR:  rf_wdata = rd_val | rs_val;
        OP_NOT: rf_wdata = ~rd_val;
        OP_INC: rf_wdata = inc17[15:0];
        OP_MOV: rf_wdata = rs_val;
        OP_IN:  rf_wdata = In;
        OP_LDI: rf_wdata = {{7{imm9[8]}}, imm9};
        OP_LDD: rf_wdata = mem_rdata;
        default: rf_wdata = '0;
      endcase
      if ((op >= OP_ADD && op <= OP_LDI) && op != OP_OUT || op == OP_LDD)
        rf_we[rd] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_gpr
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
          regs[gi] <= '0;
        else if (rf_we[gi])
          regs[gi] <= rf_wdata;
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (mem_we)
      mem[rs_val[AW-1:0]] <= rd_val;
  end

  // Control state: PC, flags, output port, halt and interrupt state
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc     <= mem[0][AW-1:0];
      z      <= 1'b0;
      n      <= 1'b0;
      c      <= 1'b0;
      Out    <= '0;
      halted <= 1'b0;
`ifdef MAD_INTERRUPT_EN
      int_q       <= 1'b0;
      pending     <= 1'b0;
      in_isr      <= 1'b0;
      epc         <= '0;
      saved_flags <= '0;
`endif
    end else begin
`ifdef MAD_INTERRUPT_EN
      int_q <= Int;
      // A new edge wins over the clear on entry, so at most one edge is kept.
      if (Int && !int_q)
        pending <= 1'b1;
      else if (take_irq)
        pending <= 1'b0;
`endif
      if (take_irq) begin
`ifdef MAD_INTERRUPT_EN
        // A halted core resumes after its HLT.
        epc         <= halted ? pc_inc : pc;
        saved_flags <= {z, n, c};
        pc          <= mem[1][AW-1:0];
        in_isr      <= 1'b1;
        halted      <= 1'b0;
`endif
      end else if (!halted) begin
        pc <= pc_inc;
        unique case (op)
          OP_ADD: {z, n, c} <= {sum17[15:0] == 16'd0, sum17[15], sum17[16]};
          OP_SUB: {z, n, c} <= {diff17[15:0] == 16'd0, diff17[15], diff17[16]};
          OP_INC: {z, n, c} <= {inc17[15:0] == 16'd0, inc17[15], inc17[16]};
          OP_AND, OP_OR, OP_NOT: begin
            z <= (rf_wdata == 16'd0);
            n <= rf_wdata[15];
          end
          OP_OUT: Out <= rd_val;
          OP_JZ: begin
            if (z) begin
              pc <= rd_val[AW-1:0];
              z  <= 1'b0;
            end
          end
          OP_JMP: pc <= rd_val[AW-1:0];
          OP_SYS: begin
            if (imm9[2:0] == 3'b000) begin
              pc     <= pc;
              halted <= 1'b1;
            end else if (imm9[2:0] == 3'b001) begin
`ifdef MAD_INTERRUPT_EN
              pc        <= epc;
              {z, n, c} <= saved_flags;
              in_isr    <= 1'b0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mad_risc_processor_core.sv
// Directed testbench for mad_risc_processor_core. It preloads the unified
// memory, then walks through a fixed program. At each step it checks Out
// and the architectural state against hand-computed values.
module tb_mad_risc_processor_core;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] In  = '0;
  logic [15:0] Out;
  logic        Int = 1'b0;

  int checks = 0;
  int errors = 0;

  mad_risc_processor_core dut (
    .Clk (Clk),
    .Rst (Rst),
    .In  (In),
    .Out (Out),
    .Int (Int)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
    $display("check %-12s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic flags(input string tag, input logic [2:0] exp_znc);
    check(tag, {13'd0, dut.z, dut.n, dut.c}, {13'd0, exp_znc});
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) dut.mem[i] = 16'h0000;
    dut.mem[0] = 16'h0010;
    dut.mem[1] = 16'h0040;
    // main program
    dut.mem[16'h10] = 16'h8200; // IN  R1
    dut.mem[16'h11] = 16'h8400; // IN  R2
    dut.mem[16'h12] = 16'h1280; // ADD R1,R2
    dut.mem[16'h13] = 16'h9200; // OUT R1
    dut.mem[16'h14] = 16'hA7FF; // LDI R3,-1
    dut.mem[16'h15] = 16'h6600; // INC R3
    dut.mem[16'h16] = 16'h9600; // OUT R3
    dut.mem[16'h17] = 16'hA820; // LDI R4,0x20
    dut.mem[16'h18] = 16'hD800; // JZ  R4
    dut.mem[16'h19] = 16'hA1FF; // not reached
    dut.mem[16'h20] = 16'hA203; // LDI R1,3
    dut.mem[16'h21] = 16'hA405; // LDI R2,5
    dut.mem[16'h22] = 16'h2280; // SUB R1,R2
    dut.mem[16'h23] = 16'h9200; // OUT R1
    dut.mem[16'h24] = 16'h8200; // IN  R1
    dut.mem[16'h25] = 16'h8400; // IN  R2
    dut.mem[16'h26] = 16'hC280; // STD M[R2]<=R1
    dut.mem[16'h27] = 16'hBA80; // LDD R5,[R2]
    dut.mem[16'h28] = 16'h9A00; // OUT R5
    dut.mem[16'h29] = 16'h7D40; // MOV R6,R5
    dut.mem[16'h2A] = 16'h5C00; // NOT R6
    dut.mem[16'h2B] = 16'h9C00; // OUT R6
    dut.mem[16'h2C] = 16'h3C80; // AND R6,R2
    dut.mem[16'h2D] = 16'h4C40; // OR  R6,R1
    dut.mem[16'h2E] = 16'h9C00; // OUT R6
    dut.mem[16'h2F] = 16'h1240; // ADD R1,R1
    dut.mem[16'h30] = 16'h9200; // OUT R1
    dut.mem[16'h31] = 16'hAE32; // LDI R7,0x32
    dut.mem[16'h32] = 16'hEE00; // JMP R7 (self loop)
    // interrupt service routine
    dut.mem[16'h40] = 16'hA077; // LDI R0,0x77
    dut.mem[16'h41] = 16'h6000; // INC R0
    dut.mem[16'h42] = 16'h9000; // OUT R0
    dut.mem[16'h43] = 16'hF001; // RTI
    // halt program (entered after the second reset)
    dut.mem[16'h50] = 16'hA0AA; // LDI R0,0xAA
    dut.mem[16'h51] = 16'h9000; // OUT R0
    dut.mem[16'h52] = 16'hF000; // HLT
    dut.mem[16'h53] = 16'hA0BB; // LDI R0,0xBB
    dut.mem[16'h54] = 16'h9000; // OUT R0

    repeat (2) tick();
    check("rst_out", Out, 16'h0000);
    check("rst_pc", 16'(dut.pc), 16'h0010);
    flags("rst_flags", 3'b000);
    Rst = 1'b1;

    In = 16'h0005; tick();
    In = 16'h0019; tick();
    tick(); tick();
    check("add_out", Out, 16'h001E);
    flags("add_flags", 3'b000);

    tick(); tick();
    flags("inc_flags", 3'b101);
    tick();
    check("inc_out", Out, 16'h0000);
    tick(); tick();
    check("jz_pc", 16'(dut.pc), 16'h0020);
    flags("jz_flags", 3'b001);

    repeat (4) tick();
    check("sub_out", Out, 16'hFFFE);
    flags("sub_flags", 3'b011);

    In = 16'hF320; tick();
    In = 16'h0100; tick();
    tick();
    check("std_mem", dut.mem[16'h100], 16'hF320);
    tick(); tick();
    check("ldd_out", Out, 16'hF320);

    tick(); tick();
    flags("not_flags", 3'b001);
    tick();
    check("not_out", Out, 16'h0CDF);
    tick();
    flags("and_flags", 3'b101);
    tick();
    flags("or_flags", 3'b011);
    tick();
    check("or_out", Out, 16'hF320);
    tick();
    flags("add2_flags", 3'b011);
    tick();
    check("add2_out", Out, 16'hE640);
    tick(); tick();
    check("loop_pc", 16'(dut.pc), 16'h0032);

    // Interrupt during the self loop
    Int = 1'b1;
    tick(); tick();
`ifdef MAD_INTERRUPT_EN
    check("irq_pc", 16'(dut.pc), 16'h0040);
    tick(); tick();
    flags("isr_flags", 3'b000);
    tick();
    check("isr_out", Out, 16'h0078);
    tick();
    check("rti_pc", 16'(dut.pc), 16'h0032);
    flags("rti_flags", 3'b011);
`else
    check("noirq_pc", 16'(dut.pc), 16'h0032);
    repeat (4) tick();
    check("noirq_pc2", 16'(dut.pc), 16'h0032);
    check("noirq_out", Out, 16'hE640);
`endif
    Int = 1'b0;

    // Asynchronous reset between edges, with a new reset vector
    #2;
    dut.mem[0] = 16'h0050;
    Rst = 1'b0;
    #1;
    check("arst_out", Out, 16'h0000);
    check("arst_pc", 16'(dut.pc), 16'h0050);
    check("arst_r1", dut.regs[1], 16'h0000);
    flags("arst_flags", 3'b000);
    tick();
    Rst = 1'b1;

    tick(); tick();
    check("hlt_pre_out", Out, 16'h00AA);
    tick();
    check("hlt_pc", 16'(dut.pc), 16'h0052);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("hlt_hold%0d", k), {Out[7:0], 3'd0, dut.pc[4:0]}, 16'hAA12);
    end

`ifdef MAD_INTERRUPT_EN
    Int = 1'b1;
    tick(); tick();
    check("hirq_pc", 16'(dut.pc), 16'h0040);
    repeat (4) tick();
    check("hrti_pc", 16'(dut.pc), 16'h0053);
    tick(); tick();
    check("hrti_out", Out, 16'h00BB);
    Int = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
